shift_deser: RTL

- Sequential serial-in/parallel-out shifter that rebuilds a WIDTH-bit word from a bit stream, one bit per accepted cycle.
- It is the receiving counterpart of the team's bidirectional shifter and serializer blocks.
- Per-frame direction select: d=1 shifts left (MSB-first stream); d=0 shifts right (LSB-first stream).
- Completed words are held in an output register with a valid/ready handshake.

---
 rtl/shift_pkg.sv | 13 +
 rtl/shift_deser_if.sv | 26 ++
 rtl/shift_deser_out_reg.sv | 53 +++++
 rtl/shift_deser.sv | 105 ++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the shifter family: direction encoding and the
// deserializer's frame state.
package shift_pkg;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/shift_deser_if.sv
// Serial input stream plus parallel-word valid/ready output of the deserializer.
interface shift_deser_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_bit;
  logic             d;
  logic             clear;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             busy;
  logic             overrun;

  modport master (
    output in_valid, in_bit, d, clear, out_ready,
    input  y, out_valid, busy, overrun
  );

  modport slave (
    input  in_valid, in_bit, d, clear, out_ready,
    output y, out_valid, busy, overrun
  );

endinterface

// File: rtl/shift_deser_out_reg.sv
// Output holding register: loads completed words, handshakes them out, and
// flags words lost while a previous one is still unconsumed.
module shift_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_word,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_y,
  output logic             o_valid,
  output logic             o_overrun
);

  logic [WIDTH-1:0] r_y;
  logic             r_valid;
  logic             r_overrun;

  // Word/valid register; a load may coincide with the consumer taking the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y     <= {WIDTH{1'b0}};
      r_valid <= 1'b0;
    end else if (i_load && (!r_valid || i_ready)) begin
      r_y     <= i_word;
      r_valid <= 1'b1;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  // Sticky overrun flag; only a frame clear releases it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (i_clear) begin
      r_overrun <= 1'b0;
    end else if (i_load && r_valid && !i_ready) begin
      r_overrun <= 1'b1;
    end else begin
      r_overrun <= r_overrun;
    end
  end

  assign o_y       = r_y;
  assign o_valid   = r_valid;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/shift_deser.sv
// Serial-in/parallel-out deserializer: rebuilds WIDTH-bit words MSB- or
// LSB-first, with the direction chosen per frame on its first bit.
module shift_deser
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  shift_deser_if.slave  bus
);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_sr, w_sr_nxt, w_shifted;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_dir, w_dir_nxt, w_dir_eff, w_done, r_busy;
  logic [WIDTH-1:0] w_y;
  logic             w_out_valid, w_overrun;

  // Shift datapath; the live d input steers only the first bit of a frame.
  always_comb begin
    w_dir_eff = (r_state == IDLE) ? bus.d : r_dir;
    if (w_dir_eff == DIR_LEFT) begin
      w_shifted = {r_sr[WIDTH-2:0], bus.in_bit};
    end else begin
      w_shifted = {bus.in_bit, r_sr[WIDTH-1:1]};
    end
  end

  // Frame FSM next-state; clear outranks an accepted bit.
  always_comb begin
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;
    w_done      = 1'b0;
    if (bus.clear) begin
      w_state_nxt = IDLE;
      w_sr_nxt    = {WIDTH{1'b0}};
      w_cnt_nxt   = {CNT_W{1'b0}};
    end else if (bus.in_valid) begin
      case (r_state)
        IDLE: begin
          w_dir_nxt   = bus.d;
          w_sr_nxt    = w_shifted;
          w_cnt_nxt   = CNT_W'(1);
          w_state_nxt = SHIFT;
        end
        SHIFT: begin
          w_sr_nxt = w_shifted;
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            w_cnt_nxt   = {CNT_W{1'b0}};
            w_state_nxt = IDLE;
            w_done      = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_sr_nxt    = {WIDTH{1'b0}};
          w_cnt_nxt   = {CNT_W{1'b0}};
        end
      endcase
    end else begin
      w_done = 1'b0;
    end
  end

  // Frame state registers; busy is registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sr    <= {WIDTH{1'b0}};
      r_cnt   <= {CNT_W{1'b0}};
      r_dir   <= DIR_RIGHT;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sr    <= w_sr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dir   <= w_dir_nxt;
      r_busy  <= (w_state_nxt == SHIFT);
    end
  end

  shift_out_reg #(.WIDTH(WIDTH)) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (bus.clear),
    .i_load    (w_done),
    .i_word    (w_sr_nxt),
    .i_ready   (bus.out_ready),
    .o_y       (w_y),
    .o_valid   (w_out_valid),
    .o_overrun (w_overrun)
  );

  assign bus.y         = w_y;
  assign bus.out_valid = w_out_valid;
  assign bus.overrun   = w_overrun;
  assign bus.busy      = r_busy;

endmodule
